// File: rtl/ref_window_loader_if.sv
// Pixel-stream and window-presentation bundle for ref_window_loader.
// The master side feeds pixels and acks windows; the slave side is the loader.
interface ref_window_loader_if #(
  parameter int WIN = 15,
  parameter int PW  = 8
);
  logic [PW-1:0]         in_data;
  logic                  in_valid;
  logic                  in_sof;
  logic                  in_ready;
  logic [WIN*WIN*PW-1:0] out_window;
  logic                  out_valid;
  logic                  out_ack;
  logic                  err_sync;
  logic [7:0]            win_count;

  modport master (
    output in_data, in_valid, in_sof, out_ack,
    input  in_ready, out_window, out_valid, err_sync, win_count
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ack,
    output in_ready, out_window, out_valid, err_sync, win_count
  );
endinterface

// File: rtl/ref_window_loader.sv
// Assembles raster pixels into WIN x WIN windows using two ping-pong banks.
// One bank fills while the other is presented until acked.
module ref_window_loader #(
  parameter int WIN = 15,
  parameter int PW  = 8
) (
  input logic clk,
  input logic rst,
  ref_window_loader_if.slave bus
);
  localparam int N = WIN * WIN;
  localparam logic [7:0] LAST = 8'(N - 1);

  logic [PW-1:0] mem [2][N];
  logic [7:0]    wr_idx;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic          err;
  logic [7:0]    cnt;

  logic       xfer;
  logic       drop;
  logic       restart;
  logic       done;
  logic       ack;
  logic [7:0] idx;

  assign bus.in_ready = rst & ~full[wr_bank];
  assign xfer    = bus.in_valid & bus.in_ready;
  assign drop    = (wr_idx == 8'd0) & ~bus.in_sof;
  assign restart = (wr_idx != 8'd0) & bus.in_sof;
  // A sof beat always lands at index 0, abandoning any partial window.
  assign idx     = bus.in_sof ? 8'd0 : wr_idx;
  assign done    = xfer & ~drop & (idx == LAST);
  assign ack     = bus.out_ack & full[rd_bank];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_idx  <= 8'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      err     <= 1'b0;
      cnt     <= 8'd0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          mem[b][i] <= '0;
    end else begin
      err <= xfer & (drop | restart);
      if (xfer && !drop) begin
        mem[wr_bank][idx] <= bus.in_data;
        wr_idx <= done ? 8'd0 : idx + 8'd1;
      end
      if (done) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
        cnt <= cnt + 8'd1;
      end
      // ack needs the read bank full, completion needs the write bank empty:
      // when both fire they always touch different banks.
      if (ack) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
    end
  end

  always_comb begin
    bus.out_window = '0;
    for (int i = 0; i < N; i++)
      bus.out_window[PW*i +: PW] = mem[rd_bank][i];
  end

  assign bus.out_valid = full[rd_bank];
  assign bus.err_sync  = err;
  assign bus.win_count = cnt;
endmodule

// File: tb/tb_ref_window_loader.sv
// Directed bench for ref_window_loader: framing, ping-pong, reset,
// plus a randomized producer/consumer run against a window queue.
module tb_ref_window_loader;
  localparam int WIN = 15;
  localparam int PW  = 8;
  localparam int N   = WIN * WIN;
  localparam int W   = N * PW;
  localparam int NW  = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ref_window_loader_if #(.WIN(WIN), .PW(PW)) bus ();

  ref_window_loader #(.WIN(WIN), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [W-1:0] expq[$];
  int consumed = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chkw(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    int bad;
    bad = -1;
    for (int i = N - 1; i >= 0; i--)
      if (got[PW*i +: PW] !== exp[PW*i +: PW]) bad = i;
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s pixel %0d got=%0h exp=%0h", tag, bad,
             got[PW*bad +: PW], exp[PW*bad +: PW]);
    end
  endtask

  function automatic logic [W-1:0] win(int mul, int add);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++)
      v[PW*k +: PW] = 8'(k * mul + add);
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic beat(input logic [7:0] d, input logic s);
    int n;
    bus.in_data  = d;
    bus.in_sof   = s;
    bus.in_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_range(int mul, int add, int from, int to);
    for (int k = from; k <= to; k++)
      beat(8'(k * mul + add), k == 0);
  endtask

  task automatic ack_pulse();
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    #1;
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.out_ack  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chkw("rst_window", bus.out_window, '0);
    chk("rst_win_count", 64'(bus.win_count), 64'd0);
    chk("rst_err", 64'(bus.err_sync), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // T1: single window k
    send_range(1, 0, 0, N - 2);
    chk("t1_valid_before", 64'(bus.out_valid), 64'd0);
    send_range(1, 0, N - 1, N - 1);
    chk("t1_valid_after", 64'(bus.out_valid), 64'd1);
    chkw("t1_window", bus.out_window, win(1, 0));
    chk("t1_r3c4", 64'(bus.out_window[8*49 +: 8]), 64'd49);
    chk("t1_win_count", 64'(bus.win_count), 64'd1);
    chk("t1_ready", 64'(bus.in_ready), 64'd1);

    // T2: second window fills bank1 without ack
    send_range(-1, 255, 0, N - 1);
    chk("t2_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t2_win_count", 64'(bus.win_count), 64'd2);
    chkw("t2_still_first", bus.out_window, win(1, 0));
    ack_pulse();
    chkw("t2_second", bus.out_window, win(-1, 255));
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_ready_after_ack", 64'(bus.in_ready), 64'd1);

    // T4: completion into one bank on the same edge as ack of the other
    send_range(3, 7, 0, N - 2);
    bus.out_ack = 1'b1;
    send_range(3, 7, N - 1, N - 1);
    bus.out_ack = 1'b0;
    #1;
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    chkw("t4_window", bus.out_window, win(3, 7));
    chk("t4_ready", 64'(bus.in_ready), 64'd1);
    chk("t4_win_count", 64'(bus.win_count), 64'd3);
    ack_pulse();
    chk("t4_drained", 64'(bus.out_valid), 64'd0);

    // T3: framing errors
    beat(8'hAA, 1'b0);
    chk("t3_drop_err", 64'(bus.err_sync), 64'd1);
    @(negedge clk);
    chk("t3_err_pulse", 64'(bus.err_sync), 64'd0);
    send_range(1, 0, 0, 99);
    chk("t3_no_err", 64'(bus.err_sync), 64'd0);
    beat(8'd200, 1'b1);
    chk("t3_resync_err", 64'(bus.err_sync), 64'd1);
    send_range(1, 200, 1, 1);
    chk("t3_err_clear", 64'(bus.err_sync), 64'd0);
    send_range(1, 200, 2, N - 2);
    chk("t3_valid_before", 64'(bus.out_valid), 64'd0);
    send_range(1, 200, N - 1, N - 1);
    chk("t3_valid_after", 64'(bus.out_valid), 64'd1);
    chkw("t3_window", bus.out_window, win(1, 200));
    chk("t3_win_count", 64'(bus.win_count), 64'd4);

    // T5: reset mid-fill with a window presented
    send_range(5, 1, 0, 49);
    rst = 1'b0;
    #1;
    chk("t5_ready_in_rst", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chkw("t5_window", bus.out_window, '0);
    chk("t5_win_count", 64'(bus.win_count), 64'd0);
    send_range(5, 1, 0, N - 1);
    chk("t5_fresh_valid", 64'(bus.out_valid), 64'd1);
    chkw("t5_fresh_window", bus.out_window, win(5, 1));
    chk("t5_fresh_count", 64'(bus.win_count), 64'd1);
    ack_pulse();

    // T6: random gaps and random ack timing
    fork
      begin
        logic [W-1:0] v;
        for (int w = 0; w < NW; w++) begin
          for (int k = 0; k < N; k++)
            v[PW*k +: PW] = 8'($urandom_range(255));
          for (int k = 0; k < N; k++) begin
            if ($urandom_range(3) == 0)
              repeat ($urandom_range(3, 1)) @(negedge clk);
            if (k == N - 1) expq.push_back(v);
            beat(v[PW*k +: PW], k == 0);
          end
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (consumed < NW && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          #1;
          if (bus.out_valid && $urandom_range(3) == 0) begin
            if (expq.size() == 0) begin
              chk("t6_unexpected", 64'd1, 64'd0);
            end else begin
              chkw("t6_window", bus.out_window, expq.pop_front());
            end
            consumed++;
            bus.out_ack = 1'b1;
            @(negedge clk);
            bus.out_ack = 1'b0;
          end
        end
        if (consumed < NW) chk("t6_timeout", 64'(consumed), 64'(NW));
      end
    join
    #1;
    chk("t6_win_count", 64'(bus.win_count), 64'((NW + 1) % 256));
    chk("t6_leftover", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
